// File: rtl/button_conditioner.sv
// Push-button conditioner: synchronizes a raw button, debounces it on a slow
// sample tick, and emits press / release / long-press pulses.
module button_conditioner #(
    parameter int SAMPLE_DIV     = 500_000,
    parameter int STABLE_SAMPLES = 4,
    parameter int HOLD_SAMPLES   = 500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pb,
    output logic       level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_pulse,
    output logic [1:0] state_dbg
);

    localparam int DIV_W  = $clog2(SAMPLE_DIV);
    localparam int MIS_W  = $clog2(STABLE_SAMPLES + 1);
    localparam int HOLD_W = $clog2(HOLD_SAMPLES + 1);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [MIS_W-1:0]  MIS_LAST  = MIS_W'(STABLE_SAMPLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_SAMPLES - 1);

    typedef enum logic [1:0] {
        RELEASED = 2'd0,
        PRESSED  = 2'd1,
        HELD     = 2'd2
    } state_t;

    logic              sync0, sync1;
    logic [DIV_W-1:0]  div_cnt;
    logic [MIS_W-1:0]  mis_cnt;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;
    state_t            state, state_nxt;
    logic              tick, qualify, rise, fall, long_d;

    assign tick      = (div_cnt == DIV_LAST);
    assign qualify   = tick && (sync1 != level) && (mis_cnt == MIS_LAST);
    assign rise      = qualify && !level;
    assign fall      = qualify && level;
    assign state_dbg = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync0         <= 1'b0;
            sync1         <= 1'b0;
            div_cnt       <= '0;
            mis_cnt       <= '0;
            level         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            hold_cnt      <= '0;
            state         <= RELEASED;
        end else begin
            sync0 <= pb;
            sync1 <= sync0;
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            // Any agreeing sample restarts qualification, so bounce never accumulates.
            if (tick) begin
                if (sync1 == level) begin
                    mis_cnt <= '0;
                end else if (qualify) begin
                    mis_cnt <= '0;
                    level   <= ~level;
                end else begin
                    mis_cnt <= mis_cnt + 1'b1;
                end
            end
            press_pulse   <= rise;
            release_pulse <= fall;
            long_pulse    <= long_d;
            hold_cnt      <= hold_nxt;
            state         <= state_nxt;
        end
    end

    // Release is tested before the hold limit so a coinciding release wins.
    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        long_d    = 1'b0;
        case (state)
            RELEASED: begin
                if (rise) begin
                    state_nxt = PRESSED;
                    hold_nxt  = '0;
                end
            end
            PRESSED: begin
                if (fall) begin
                    state_nxt = RELEASED;
                end else if (tick) begin
                    if (hold_cnt == HOLD_LAST) begin
                        state_nxt = HELD;
                        long_d    = 1'b1;
                    end else begin
                        hold_nxt = hold_cnt + 1'b1;
                    end
                end
            end
            HELD: begin
                if (fall) state_nxt = RELEASED;
            end
            default: state_nxt = RELEASED;
        endcase
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: stimulus pushes expected pulse events
// (kind + cycle) into a queue, a negedge monitor pops and compares each pulse.
module tb_button_conditioner;

  localparam int D = 4;
  localparam int S = 3;
  localparam int H = 8;

  localparam logic [1:0] EV_PRESS   = 2'd1;
  localparam logic [1:0] EV_RELEASE = 2'd2;
  localparam logic [1:0] EV_LONG    = 2'd3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pb = 1'b0;
  logic       level, press_pulse, release_pulse, long_pulse;
  logic [1:0] state_dbg;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int r_base = 0;

  logic [33:0] exp_q[$];

  button_conditioner #(
    .SAMPLE_DIV(D),
    .STABLE_SAMPLES(S),
    .HOLD_SAMPLES(H)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pb(pb),
    .level(level),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .long_pulse(long_pulse),
    .state_dbg(state_dbg)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached act=%0d req=finished", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: act=%0h req=%0h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  // First sample tick at or after cycle x, given ticks land D cycles apart from reset release.
  function automatic int next_tick(input int x);
    int t;
    t = x;
    while (t <= r_base || ((t - r_base) % D) != 0) t++;
    return t;
  endfunction

  // pb changed at the negedge of cycle c: two sync stages, then S agreeing ticks.
  task automatic expect_edge(input logic [1:0] code, input int c, output int ev);
    ev = next_tick(c + 3) + (S - 1) * D;
    exp_q.push_back({code, 32'(ev)});
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic drive_pb(input logic v, input logic [1:0] code, output int ev);
    pb = v;
    expect_edge(code, cyc, ev);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    int n;
    logic [1:0] code;
    logic [33:0] e;
    if (!rst && (press_pulse || release_pulse || long_pulse)) begin
      n = int'(press_pulse) + int'(release_pulse) + int'(long_pulse);
      checks++;
      if (n != 1) begin
        failures++;
        $display("FAIL onehot: act=%0d pulses high req=1 (cyc %0d)", n, cyc);
      end
      code = press_pulse ? EV_PRESS : (release_pulse ? EV_RELEASE : EV_LONG);
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse: act kind=%0d cyc=%0d req=none", code, cyc);
      end else begin
        e = exp_q.pop_front();
        if (e != {code, 32'(cyc)}) begin
          failures++;
          $display("FAIL pulse_event: act kind=%0d cyc=%0d req kind=%0d cyc=%0d",
                   code, cyc, e[33:32], e[31:0]);
        end
      end
      checks++;
      if (level != (code != EV_RELEASE)) begin
        failures++;
        $display("FAIL pulse_level: act=%0b req=%0b (cyc %0d)", level, code != EV_RELEASE, cyc);
      end
      checks++;
      if (state_dbg != ((code == EV_PRESS) ? 2'd1 : (code == EV_LONG) ? 2'd2 : 2'd0)) begin
        failures++;
        $display("FAIL pulse_state: act=%0d kind=%0d (cyc %0d)", state_dbg, code, cyc);
      end
    end
  end

  // stimulus
  initial begin
    int p, rel, c, lp;

    repeat (3) @(negedge clk);
    check("reset_outputs", {27'd0, level, press_pulse, release_pulse, long_pulse, state_dbg}, 32'd0);
    rst = 1'b0;
    r_base = cyc;
    wait_until(r_base + 10);
    check("idle_level", {31'd0, level}, 32'd0);

    // clean press held into a long press, then release
    drive_pb(1'b1, EV_PRESS, p);
    check("press_latency_window", 32'((p - cyc) >= 11 && (p - cyc) <= 15), 32'd1);
    lp = p + H * D;
    exp_q.push_back({EV_LONG, 32'(lp)});
    wait_until(p + 60);
    drive_pb(1'b0, EV_RELEASE, rel);
    wait_until(rel + 4);
    check("long_release_level", {31'd0, level}, 32'd0);
    check("long_release_state", {30'd0, state_dbg}, 32'd0);

    // bounce: toggle every 3 clk for 40 clk, then settle low
    for (int k = 0; k < 40; k++) begin
      pb = ((k / 3) % 2) == 0;
      @(negedge clk);
    end
    pb = 1'b0;
    wait_until(cyc + 24);
    check("bounce_level", {31'd0, level}, 32'd0);

    // short press: high for 20 clk
    c = cyc;
    drive_pb(1'b1, EV_PRESS, p);
    wait_until(c + 20);
    drive_pb(1'b0, EV_RELEASE, rel);
    wait_until(rel + 4);
    check("short_level", {31'd0, level}, 32'd0);

    // release qualifies on the same tick as the last hold tick
    drive_pb(1'b1, EV_PRESS, p);
    wait_until(p + 21);
    drive_pb(1'b0, EV_RELEASE, rel);
    check("collision_alignment", 32'(rel), 32'(p + H * D));
    wait_until(p + H * D + 12);
    check("collision_state", {30'd0, state_dbg}, 32'd0);

    // reset during PRESSED with pb still high
    drive_pb(1'b1, EV_PRESS, p);
    wait_until(p + 10);
    check("pre_reset_state", {30'd0, state_dbg}, 32'd1);
    rst = 1'b1;
    #1;
    check("async_reset_outputs", {27'd0, level, press_pulse, release_pulse, long_pulse, state_dbg}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    r_base = cyc;
    expect_edge(EV_PRESS, cyc, p);
    check("post_reset_press_cycle", 32'(p - r_base), 32'd12);
    wait_until(p + 6);
    drive_pb(1'b0, EV_RELEASE, rel);
    wait_until(rel + 20);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
